// File: rtl/instr_emitter.sv
// Turns one abstract operation into the 9-bit instruction beats the Control decoder consumes,
// inserting setdes/setsrc prefixes only when the tracked DesReg/SrcReg pointers disagree.
module instr_emitter (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opcode,
    input  logic [2:0]  req_func,
    input  logic [2:0]  req_dst,
    input  logic [2:0]  req_src,
    input  logic [5:0]  req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [8:0]  instr,
    output logic        illegal,
    output logic        halted,
    output logic [15:0] instr_count
);
    typedef enum logic [2:0] {IDLE, EMIT_DES, EMIT_SRC, EMIT_OP, HALT} state_t;

    state_t      state_reg;
    state_t      sel_state;
    logic [2:0]  op_reg, func_reg, dst_reg, src_reg;
    logic [5:0]  imm_reg;
    logic [8:0]  instr_reg;
    logic        instr_valid_reg, illegal_reg, halted_reg;
    logic [15:0] count_reg;
    logic [2:0]  shadow_des_reg, shadow_src_reg, shadow_des_next, shadow_src_next;
    logic        des_known_reg, src_known_reg, des_known_next, src_known_next;

    logic        beat_taken, req_illegal, uses_regs, is_idle;
    logic [2:0]  cur_op, cur_func, cur_dst, cur_src;
    logic [5:0]  cur_imm;
    logic [8:0]  sel_word;

    always_comb begin
        beat_taken      = instr_valid_reg && instr_ready;
        shadow_des_next = shadow_des_reg;
        shadow_src_next = shadow_src_reg;
        des_known_next  = des_known_reg;
        src_known_next  = src_known_reg;
        // Any accepted setdes/setsrc beat moves the pointer, prefix or explicit alike.
        if (beat_taken && instr_reg[8:3] == 6'b001_000) begin
            shadow_des_next = instr_reg[2:0];
            des_known_next  = 1'b1;
        end
        if (beat_taken && instr_reg[8:3] == 6'b001_001) begin
            shadow_src_next = instr_reg[2:0];
            src_known_next  = 1'b1;
        end

        is_idle  = (state_reg == IDLE);
        cur_op   = is_idle ? req_opcode : op_reg;
        cur_func = is_idle ? req_func   : func_reg;
        cur_dst  = is_idle ? req_dst    : dst_reg;
        cur_src  = is_idle ? req_src    : src_reg;
        cur_imm  = is_idle ? req_imm    : imm_reg;

        req_illegal = (req_opcode == 3'd7) ||
                      (req_opcode == 3'd0 && req_func == 3'd0) ||
                      (req_opcode == 3'd1 && req_func >= 3'd6);
        uses_regs   = (cur_op == 3'd0) ||
                      (cur_op == 3'd1 && cur_func >= 3'd2 && cur_func <= 3'd4);

        if (uses_regs && (!des_known_next || shadow_des_next != cur_dst))
            sel_state = EMIT_DES;
        else if (uses_regs && (!src_known_next || shadow_src_next != cur_src))
            sel_state = EMIT_SRC;
        else
            sel_state = EMIT_OP;

        case (sel_state)
            EMIT_DES: sel_word = {3'd1, 3'd0, cur_dst};
            EMIT_SRC: sel_word = {3'd1, 3'd1, cur_src};
            default: begin
                if (cur_op == 3'd0)
                    sel_word = {3'd0, cur_func, 3'd0};
                else if (cur_op == 3'd1 && cur_func == 3'd0)
                    sel_word = {3'd1, 3'd0, cur_dst};
                else if (cur_op == 3'd1 && cur_func == 3'd1)
                    sel_word = {3'd1, 3'd1, cur_src};
                else if (cur_op == 3'd1)
                    sel_word = {3'd1, cur_func, 3'd0};
                else
                    sel_word = {cur_op, cur_imm};
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg       <= IDLE;
            op_reg          <= 3'd0;
            func_reg        <= 3'd0;
            dst_reg         <= 3'd0;
            src_reg         <= 3'd0;
            imm_reg         <= 6'd0;
            instr_reg       <= 9'd0;
            instr_valid_reg <= 1'b0;
            illegal_reg     <= 1'b0;
            halted_reg      <= 1'b0;
            count_reg       <= 16'd0;
            shadow_des_reg  <= 3'd0;
            shadow_src_reg  <= 3'd0;
            des_known_reg   <= 1'b0;
            src_known_reg   <= 1'b0;
        end else begin
            illegal_reg    <= 1'b0;
            shadow_des_reg <= shadow_des_next;
            shadow_src_reg <= shadow_src_next;
            des_known_reg  <= des_known_next;
            src_known_reg  <= src_known_next;
            if (beat_taken)
                count_reg <= count_reg + 16'd1;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (req_illegal) begin
                            illegal_reg <= 1'b1;
                        end else begin
                            op_reg          <= req_opcode;
                            func_reg        <= req_func;
                            dst_reg         <= req_dst;
                            src_reg         <= req_src;
                            imm_reg         <= req_imm;
                            state_reg       <= sel_state;
                            instr_reg       <= sel_word;
                            instr_valid_reg <= 1'b1;
                        end
                    end
                end
                EMIT_DES, EMIT_SRC: begin
                    if (beat_taken) begin
                        state_reg <= sel_state;
                        instr_reg <= sel_word;
                    end
                end
                EMIT_OP: begin
                    if (beat_taken) begin
                        instr_valid_reg <= 1'b0;
                        if (op_reg == 3'd1 && func_reg == 3'd5) begin
                            state_reg  <= HALT;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                HALT: state_reg <= HALT;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_reg == IDLE);
    assign instr_valid = instr_valid_reg;
    assign instr       = instr_reg;
    assign illegal     = illegal_reg;
    assign halted      = halted_reg;
    assign instr_count = count_reg;
endmodule

// File: tb/tb_instr_emitter.sv
// Directed plus randomized bench for instr_emitter; expected beats come from a
// pointer-tracking model of the prefix rules, checked with immediate assertions.
module tb_instr_emitter;
    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_opcode = 3'd0, req_func = 3'd0, req_dst = 3'd0, req_src = 3'd0;
    logic [5:0]  req_imm = 6'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [8:0]  instr;
    logic        illegal, halted;
    logic [15:0] instr_count;

    instr_emitter dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_func(req_func),
        .req_dst(req_dst), .req_src(req_src), .req_imm(req_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .illegal(illegal), .halted(halted), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: what the decoder believes DesReg/SrcReg hold.
    bit          m_des_known, m_src_known;
    logic [2:0]  m_des, m_src;
    logic [15:0] m_count;
    logic [8:0]  exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_des_known = 0; m_src_known = 0; m_des = 0; m_src = 0; m_count = 0;
        exp_q.delete();
    endtask

    task automatic model_req(input logic [2:0] op, input logic [2:0] fn, input logic [2:0] d,
                             input logic [2:0] s, input logic [5:0] imm,
                             output bit ill, output bit dn);
        bit uses;
        ill  = (op == 3'd7) || (op == 3'd0 && fn == 3'd0) || (op == 3'd1 && fn >= 3'd6);
        dn   = (op == 3'd1 && fn == 3'd5);
        uses = (op == 3'd0) || (op == 3'd1 && (fn == 3'd2 || fn == 3'd3 || fn == 3'd4));
        if (ill) return;
        if (uses && !(m_des_known && m_des == d)) begin
            exp_q.push_back({3'd1, 3'd0, d}); m_des_known = 1; m_des = d;
        end
        if (uses && !(m_src_known && m_src == s)) begin
            exp_q.push_back({3'd1, 3'd1, s}); m_src_known = 1; m_src = s;
        end
        if (op == 3'd0) exp_q.push_back({3'd0, fn, 3'd0});
        else if (op == 3'd1 && fn == 3'd0) begin
            exp_q.push_back({3'd1, 3'd0, d}); m_des_known = 1; m_des = d;
        end else if (op == 3'd1 && fn == 3'd1) begin
            exp_q.push_back({3'd1, 3'd1, s}); m_src_known = 1; m_src = s;
        end else if (op == 3'd1) exp_q.push_back({3'd1, fn, 3'd0});
        else exp_q.push_back({op, imm});
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge CLK);
        check("rst_valid", 16'(instr_valid), 16'd0);
        check("rst_instr", 16'(instr), 16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_count", instr_count, 16'd0);
        Reset_n = 1'b1;
        @(negedge CLK);
        check("rst_ready", 16'(req_ready), 16'd1);
    endtask

    // Issue one request; stall holds instr_ready low for that many beat cycles first.
    task automatic run_req(input logic [2:0] op, input logic [2:0] fn, input logic [2:0] d,
                           input logic [2:0] s, input logic [5:0] imm,
                           input int stall, input bit rnd);
        bit ill, dn, r;
        int budget;
        model_req(op, fn, d, s, imm, ill, dn);
        check("req_ready", 16'(req_ready), 16'd1);
        req_valid = 1'b1; req_opcode = op; req_func = fn; req_dst = d; req_src = s; req_imm = imm;
        instr_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
        req_valid = 1'b0;
        req_opcode = 3'($urandom); req_func = 3'($urandom);
        req_dst = 3'($urandom); req_src = 3'($urandom); req_imm = 6'($urandom);
        if (ill) begin
            check("ill_pulse", 16'(illegal), 16'd1);
            check("ill_no_beat", 16'(instr_valid), 16'd0);
            @(negedge CLK);
            check("ill_clear", 16'(illegal), 16'd0);
            check("ill_no_beat2", 16'(instr_valid), 16'd0);
            check("ill_ready", 16'(req_ready), 16'd1);
            check("ill_count", instr_count, m_count);
            return;
        end
        check("no_illegal", 16'(illegal), 16'd0);
        budget = 0;
        while (exp_q.size() > 0) begin
            if (budget > 200) begin
                n_cmp++; n_fail++;
                $error("FAIL beat_timeout: observed %0d beats pending expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
            check("beat_valid", 16'(instr_valid), 16'd1);
            check("beat_word", 16'(instr), 16'(exp_q[0]));
            if (budget < stall) r = 1'b0;
            else if (rnd) r = ($urandom_range(0, 3) != 0);
            else r = 1'b1;
            instr_ready = r;
            @(negedge CLK);
            budget++;
            if (r) begin
                void'(exp_q.pop_front());
                m_count = m_count + 16'd1;
            end
        end
        instr_ready = 1'($urandom_range(0, 1));
        check("end_valid", 16'(instr_valid), 16'd0);
        check("end_count", instr_count, m_count);
        check("end_halted", 16'(halted), 16'(dn));
        check("end_ready", 16'(req_ready), 16'(!dn));
        $display("req op=%0d func=%0d dst=%0d src=%0d imm=%0h -> count=%0h", op, fn, d, s, imm, instr_count);
    endtask

    initial begin
        logic [2:0] op, fn;
        bit ill, dn;
        do_reset();

        // Cold R-type, then pointer reuse.
        run_req(3'd0, 3'd5, 3'd2, 3'd3, 6'd0, 0, 0);
        run_req(3'd0, 3'd3, 3'd2, 3'd3, 6'd0, 0, 0);
        run_req(3'd0, 3'd3, 3'd2, 3'd5, 6'd0, 0, 0);
        // Stalled I-type mov.
        run_req(3'd2, 3'd0, 3'd0, 3'd0, 6'h2A, 5, 0);
        // Illegal variants.
        run_req(3'd7, 3'd0, 3'd0, 3'd0, 6'd0, 0, 0);
        run_req(3'd0, 3'd0, 3'd1, 3'd1, 6'd0, 0, 0);
        run_req(3'd1, 3'd6, 3'd1, 3'd1, 6'd0, 0, 0);
        // Explicit setdes/setsrc then memory op that should need no prefix.
        run_req(3'd1, 3'd0, 3'd6, 3'd0, 6'd0, 0, 0);
        run_req(3'd1, 3'd1, 3'd0, 3'd7, 6'd0, 0, 0);
        run_req(3'd1, 3'd3, 3'd6, 3'd7, 6'd0, 2, 0);

        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            fn = 3'($urandom);
            if (op == 3'd1 && fn == 3'd5) fn = 3'd4;
            run_req(op, fn, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 6'($urandom), 0, 1);
        end

        // Done: halts and ignores later requests.
        run_req(3'd1, 3'd5, 3'd0, 3'd0, 6'd0, 0, 0);
        req_valid = 1'b1; req_opcode = 3'd0; req_func = 3'd1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("halt_no_beat", 16'(instr_valid), 16'd0);
            check("halt_ready", 16'(req_ready), 16'd0);
            check("halt_count", instr_count, m_count);
            check("halt_flag", 16'(halted), 16'd1);
        end
        req_valid = 1'b0;

        // Reset while the source prefix is pending.
        do_reset();
        run_req(3'd2, 3'd0, 3'd0, 3'd0, 6'h11, 0, 0);
        model_req(3'd0, 3'd1, 3'd5, 3'd4, 6'd0, ill, dn);
        req_valid = 1'b1; req_opcode = 3'd0; req_func = 3'd1; req_dst = 3'd5; req_src = 3'd4;
        instr_ready = 1'b0;
        @(negedge CLK);
        req_valid = 1'b0;
        check("mid_des", 16'(instr), 16'(exp_q[0]));
        instr_ready = 1'b1;
        @(negedge CLK);
        instr_ready = 1'b0;
        check("mid_src", 16'(instr), 16'(exp_q[1]));
        check("mid_src_valid", 16'(instr_valid), 16'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_valid", 16'(instr_valid), 16'd0);
        check("abort_count", instr_count, 16'd0);
        check("abort_instr", 16'(instr), 16'd0);
        model_clear();
        @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        run_req(3'd0, 3'd1, 3'd5, 3'd4, 6'd0, 0, 0);
        check("cold_count", instr_count, 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
